// File: rtl/cpu_sequencer_pkg.sv
// Shared types for the cpu instruction sequencer: FSM state encoding and
// instruction/flag widths.
package cpu_sequencer_pkg;

    localparam int INSTR_W = 16;
    localparam int FLAG_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        EXEC,
        CAPT,
        FIN
    } seq_state_e;

endpackage

// File: rtl/seq_instr_buf.sv
// Instruction buffer: DEPTH x INSTR_W register file, one synchronous write
// port and one combinational read port. Contents are deliberately not reset.
module seq_instr_buf
    import cpu_sequencer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               i_wr_en,
    input  logic [ADDR_W-1:0]  i_wr_addr,
    input  logic [INSTR_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0]  i_rd_addr,
    output logic [INSTR_W-1:0] o_rd_data
);

    logic [INSTR_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/cpu_sequencer.sv
// Issues buffered instructions to the simple cpu over its s/load/in/w
// handshake and reports each result with its flags; aborts a stalled run.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic               start,
    input  logic [ADDR_W:0]    count,
    output logic [INSTR_W-1:0] cpu_in,
    output logic               cpu_load,
    output logic               cpu_s,
    input  logic               cpu_w,
    input  logic [INSTR_W-1:0] cpu_out,
    input  logic               cpu_N,
    input  logic               cpu_V,
    input  logic               cpu_Z,
    output logic               busy,
    output logic               res_valid,
    output logic [INSTR_W-1:0] res_data,
    output logic [FLAG_W-1:0]  res_flags,
    output logic [ADDR_W-1:0]  res_index,
    output logic               done,
    output logic               timeout_err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    seq_state_e         r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W:0]    r_count;
    logic [TMO_W-1:0]   r_tmo;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [INSTR_W-1:0] w_rd_data;
    logic               w_wr_en;
    logic               w_last;
    logic               w_tmo_hit;

    assign w_wr_en   = wr_en && (r_state == IDLE);
    assign w_last    = (({1'b0, r_pc} + (ADDR_W+1)'(1)) == r_count);
    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT - 1));

    // Read ahead so cpu_in can be registered on the edge that enters LOAD.
    always_comb begin
        w_rd_addr = r_pc;
        if (r_state == IDLE) begin
            w_rd_addr = '0;
        end else if (r_state == CAPT) begin
            w_rd_addr = r_pc + ADDR_W'(1);
        end
    end

    seq_instr_buf #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_count     <= '0;
            r_tmo       <= '0;
            cpu_in      <= '0;
            cpu_load    <= 1'b0;
            cpu_s       <= 1'b0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_flags   <= '0;
            res_index   <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            cpu_load  <= 1'b0;
            res_valid <= 1'b0;
            done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                        if (count != '0) begin
                            r_count  <= count;
                            r_pc     <= '0;
                            cpu_in   <= w_rd_data;
                            cpu_load <= 1'b1;
                            r_state  <= LOAD;
                        end else begin
                            done    <= 1'b1;
                            r_state <= FIN;
                        end
                    end
                end
                LOAD: begin
                    cpu_s   <= 1'b1;
                    r_tmo   <= '0;
                    r_state <= START;
                end
                START: begin
                    if (!cpu_w) begin
                        cpu_s   <= 1'b0;
                        r_tmo   <= '0;
                        r_state <= EXEC;
                    end else if (w_tmo_hit) begin
                        cpu_s       <= 1'b0;
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        r_state     <= FIN;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                EXEC: begin
                    if (cpu_w) begin
                        res_valid <= 1'b1;
                        res_data  <= cpu_out;
                        res_flags <= {cpu_N, cpu_V, cpu_Z};
                        res_index <= r_pc;
                        r_state   <= CAPT;
                    end else if (w_tmo_hit) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        r_state     <= FIN;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                CAPT: begin
                    if (w_last) begin
                        done    <= 1'b1;
                        r_state <= FIN;
                    end else begin
                        r_pc     <= w_rd_addr;
                        cpu_in   <= w_rd_data;
                        cpu_load <= 1'b1;
                        r_state  <= LOAD;
                    end
                end
                FIN: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a behavioural simple-cpu model answers the
// handshake; a scoreboard holds the results each program must produce.
module tb_cpu_sequencer;

    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [15:0]       wr_data = '0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   count = '0;
    logic [15:0]       cpu_in;
    logic              cpu_load;
    logic              cpu_s;
    logic              cpu_w = 1'b1;
    logic [15:0]       cpu_out = '0;
    logic              cpu_N = 1'b0;
    logic              cpu_V = 1'b0;
    logic              cpu_Z = 1'b0;
    logic              busy;
    logic              res_valid;
    logic [15:0]       res_data;
    logic [2:0]        res_flags;
    logic [ADDR_W-1:0] res_index;
    logic              done;
    logic              timeout_err;

    cpu_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .count(count), .cpu_in(cpu_in), .cpu_load(cpu_load), .cpu_s(cpu_s),
        .cpu_w(cpu_w), .cpu_out(cpu_out), .cpu_N(cpu_N), .cpu_V(cpu_V), .cpu_Z(cpu_Z),
        .busy(busy), .res_valid(res_valid), .res_data(res_data), .res_flags(res_flags),
        .res_index(res_index), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_done, n_valid, n_load, n_s;
    logic te_first;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Simple-cpu model: opcode 110 = MOV (imm / shifted reg), 101 = ADD/CMP/AND/MVN.
    logic [15:0] ir = '0;
    logic [15:0] rf [8];
    logic        cpu_busy = 1'b0;
    logic        cpu_stuck = 1'b0;
    int          cpu_lat = 2;
    int          lat_cnt = 0;

    always @(posedge clk) begin : cpu_model
        logic [15:0] a, m, b, r;
        if (cpu_load) ir <= cpu_in;
        if (!cpu_busy) begin
            if (cpu_s && !cpu_stuck) begin
                cpu_busy <= 1'b1;
                cpu_w    <= 1'b0;
                lat_cnt  <= cpu_lat;
            end
        end else if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt - 1;
        end else begin
            cpu_busy <= 1'b0;
            cpu_w    <= 1'b1;
            a = rf[ir[10:8]];
            m = rf[ir[2:0]];
            case (ir[4:3])
                2'd0:    b = m;
                2'd1:    b = m << 1;
                2'd2:    b = m >> 1;
                default: b = {m[15], m[15:1]};
            endcase
            if (ir[15:13] == 3'b110) begin
                r = ir[12] ? {{8{ir[7]}}, ir[7:0]} : b;
                if (ir[12]) rf[ir[10:8]] <= r;
                else        rf[ir[7:5]]  <= r;
                cpu_out <= r;
            end else begin
                case (ir[12:11])
                    2'd0:    r = a + b;
                    2'd1:    r = a - b;
                    2'd2:    r = a & b;
                    default: r = ~b;
                endcase
                cpu_N <= r[15];
                cpu_Z <= (r == 16'h0000);
                cpu_V <= (ir[12:11] == 2'd0) ? (a[15] == b[15] && r[15] != a[15]) :
                         (ir[12:11] == 2'd1) ? (a[15] != b[15] && r[15] != a[15]) : 1'b0;
                if (ir[12:11] != 2'd1) begin
                    rf[ir[7:5]] <= r;
                    cpu_out     <= r;
                end
            end
        end
    end

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] d;
        logic [2:0]  f;
    } exp_t;
    exp_t sb [$];

    typedef struct packed {
        logic [15:0][15:0] prog;
        logic [15:0][15:0] d;
        logic [15:0][2:0]  f;
        logic [4:0]        cnt;
    } vec_t;
    vec_t vt [6];

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done)     n_done++;
        if (cpu_load) n_load++;
        if (cpu_s)    n_s++;
        if (res_valid) begin
            n_valid++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL res_valid: got pulse at index %0d expected none", res_index);
            end else begin
                e = sb.pop_front();
                chk("res_index", 64'(res_index), 64'(e.idx));
                chk("res_data",  64'(res_data),  64'(e.d));
                chk("res_flags", 64'(res_flags), 64'(e.f));
            end
        end
    end

    task automatic push(input int i, input logic [15:0] d, input logic [2:0] f);
        exp_t e;
        e.idx = 4'(i);
        e.d   = d;
        e.f   = f;
        sb.push_back(e);
    endtask

    task automatic addv(input int v, input int i, input logic [15:0] p,
                        input logic [15:0] d, input logic [2:0] f);
        vt[v].prog[i] = p;
        vt[v].d[i]    = d;
        vt[v].f[i]    = f;
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic run(input int cnt, input int budget, input bit disturb, output int dcyc);
        int cyc;
        @(negedge clk);
        n_done = 0; n_valid = 0; n_load = 0; n_s = 0;
        dcyc  = -1;
        start = 1'b1;
        count = (ADDR_W+1)'(cnt);
        for (cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start    = 1'b0;
                te_first = timeout_err;
            end
            if (disturb && cyc == 3) begin
                wr_en = 1'b1; wr_addr = 1; wr_data = 16'hD0FF;
                start = 1'b1; count = 1;
            end
            if (cyc == 4) begin
                wr_en = 1'b0;
                start = 1'b0;
            end
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        wr_en = 1'b0;
        start = 1'b0;
        if (dcyc < 0) begin
            total++;
            bad++;
            $display("FAIL run_done: got no done within %0d cycles expected done", budget);
        end else begin
            @(negedge clk);
            chk("busy_after_done", 64'({busy, done}), 64'(0));
        end
    endtask

    task automatic wait_cpu_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (cpu_w && !cpu_busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("cpu_model_idle", 64'(ok), 64'(1));
    endtask

    task automatic mid_reset(input bit in_start);
        bit hit = 1'b0;
        cpu_stuck = in_start;
        cpu_lat   = 10;
        @(negedge clk);
        start = 1'b1;
        count = 1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (in_start ? cpu_s : (busy && !cpu_s && !cpu_w)) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(in_start ? "reach_START" : "reach_EXEC", 64'(hit), 64'(1));
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({cpu_s, cpu_load, busy, res_valid, done}), 64'(0));
        @(negedge clk);
        reset     = 1'b1;
        cpu_stuck = 1'b0;
        wait_cpu_idle();
        cpu_lat = 2;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int dc;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'({cpu_in, cpu_load, cpu_s, busy, res_valid, res_data,
                                  res_flags, res_index, done, timeout_err}), 64'(0));
        reset = 1'b1;

        vt[0].cnt = 2;
        addv(0, 0, 16'hD004, 16'h0004, 3'b000); addv(0, 1, 16'hC020, 16'h0004, 3'b000);
        vt[1].cnt = 4;
        addv(1, 0, 16'hD004, 16'h0004, 3'b000); addv(1, 1, 16'hC020, 16'h0004, 3'b000);
        addv(1, 2, 16'hD273, 16'h0073, 3'b000); addv(1, 3, 16'hA269, 16'h007B, 3'b000);
        vt[2].cnt = 3;
        addv(2, 0, 16'hD004, 16'h0004, 3'b000); addv(2, 1, 16'hC020, 16'h0004, 3'b000);
        addv(2, 2, 16'hA801, 16'h0004, 3'b001);
        vt[3].cnt = 3;
        addv(3, 0, 16'hD004, 16'h0004, 3'b001); addv(3, 1, 16'hC020, 16'h0004, 3'b001);
        addv(3, 2, 16'hA809, 16'h0004, 3'b100);
        vt[4].cnt = 4;
        addv(4, 0, 16'hD30F, 16'h000F, 3'b100); addv(4, 1, 16'hD40A, 16'h000A, 3'b100);
        addv(4, 2, 16'hB3A4, 16'h000A, 3'b000); addv(4, 3, 16'hB8C5, 16'hFFF5, 3'b100);
        vt[5].cnt = 5'(DEPTH);
        for (int i = 0; i < DEPTH; i++) addv(5, i, 16'hD000 | 16'(i + 1), 16'(i + 1), 3'b100);

        for (int v = 0; v < 6; v++) begin
            cpu_lat = v;
            for (int i = 0; i < int'(vt[v].cnt); i++) wr(i, vt[v].prog[i]);
            for (int i = 0; i < int'(vt[v].cnt); i++) push(i, vt[v].d[i], vt[v].f[i]);
            run(int'(vt[v].cnt), 600, 1'b0, dc);
            chk("vec_n_valid", 64'(n_valid), 64'(vt[v].cnt));
            chk("vec_n_load",  64'(n_load),  64'(vt[v].cnt));
            chk("vec_n_done",  64'(n_done),  64'(1));
            chk("vec_sb_left", 64'(sb.size()), 64'(0));
            repeat (3) @(negedge clk);
            chk("vec_res_hold", 64'(res_data), 64'(vt[v].d[vt[v].cnt - 1]));
        end

        cpu_lat = 2;
        run(0, 20, 1'b0, dc);
        chk("cnt0_done_cycle", 64'(dc), 64'(1));
        chk("cnt0_activity", 64'({n_valid[7:0], n_load[7:0], n_s[7:0]}), 64'(0));
        chk("cnt0_n_done", 64'(n_done), 64'(1));

        wr(0, 16'hD004);
        wr(1, 16'hC020);
        push(0, 16'h0004, 3'b100);
        push(1, 16'h0004, 3'b100);
        run(2, 200, 1'b1, dc);
        chk("busy_ignore_n_valid", 64'(n_valid), 64'(2));
        chk("busy_ignore_n_done",  64'(n_done),  64'(1));
        chk("busy_ignore_sb_left", 64'(sb.size()), 64'(0));

        cpu_stuck = 1'b1;
        run(1, 200, 1'b0, dc);
        chk("tmo_start_err",     64'(timeout_err), 64'(1));
        chk("tmo_start_s_cycles", 64'(n_s),        64'(TIMEOUT));
        chk("tmo_start_n_valid", 64'(n_valid),     64'(0));
        chk("tmo_start_n_done",  64'(n_done),      64'(1));
        cpu_stuck = 1'b0;
        push(0, 16'h0004, 3'b100);
        run(1, 200, 1'b0, dc);
        chk("start_clears_err", 64'(te_first), 64'(0));
        chk("after_tmo_n_valid", 64'(n_valid), 64'(1));

        cpu_lat = 100;
        run(1, 300, 1'b0, dc);
        chk("tmo_exec_err",     64'(timeout_err), 64'(1));
        chk("tmo_exec_n_valid", 64'(n_valid),     64'(0));
        chk("tmo_exec_n_done",  64'(n_done),      64'(1));
        wait_cpu_idle();
        cpu_lat = 2;

        mid_reset(1'b0);
        mid_reset(1'b1);
        chk("reset_clears_err", 64'(timeout_err), 64'(0));
        sb.delete();
        push(0, 16'h0004, 3'b100);
        run(1, 200, 1'b0, dc);
        chk("post_reset_n_valid", 64'(n_valid), 64'(1));
        chk("post_reset_sb_left", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
